// File: rtl/bus_pkg.sv
// Shared bus definitions for the serial address decoder.
//   addr_dec_state_t : decoder FSM state encoding (IDLE, SHIFT, HOLD)
//   MAX_SLAVES       : largest slave count a decoder may be built for
package bus_pkg;

    localparam int unsigned MAX_SLAVES = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } addr_dec_state_t;

endpackage

// File: rtl/addr_bit_counter.sv
// Bit counter for the serial address shifter.
// Ports:
//   CLK   - clock, rising edge
//   RSTN  - asynchronous active-low reset, clears the count
//   clr   - synchronous clear (has priority over inc)
//   inc   - increment by one
//   count - current count, WIDTH bits
module addr_bit_counter
    import bus_pkg::*;
#(
    parameter int unsigned WIDTH = 2
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/serial_addr_decoder.sv
// Serial address decoder: shifts an LSB-first slave address off the serial
// bus during the address phase, holds it for the data phase and drives a
// one-hot slave select (AD_SEL) or, for split-capable slaves that report
// split-busy, a one-hot split-pending select (SPL_SEL).
//
// Build option: define SERIAL_ADDR_PARITY_EN to expect one even-parity bit
// after the address; a parity mismatch holds the address with ADDR_ERR set.
//
// Ports:
//   CLK        - clock, rising edge
//   RSTN       - asynchronous active-low reset
//   B_UTIL     - bus utilised, qualifies all other bus inputs
//   A_ADD      - address phase, address bits are on B_BUS_OUT
//   B_BUS_OUT  - serial bus bit
//   B_SBSY     - per-slave split-busy
//   AD_SEL     - one-hot slave select
//   SPL_SEL    - one-hot split-pending select
//   ADDR_VALID - decoded address held and valid
//   ADDR_ERR   - held address selects no slave, or parity failed
module serial_addr_decoder
    import bus_pkg::*;
#(
    parameter int unsigned               NUM_SLAVES = 3,
    parameter logic [NUM_SLAVES-1:0]     SPLIT_MASK = NUM_SLAVES'(1)
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  B_UTIL,
    input  logic                  A_ADD,
    input  logic                  B_BUS_OUT,
    input  logic [NUM_SLAVES-1:0] B_SBSY,
    output logic [NUM_SLAVES-1:0] AD_SEL,
    output logic [NUM_SLAVES-1:0] SPL_SEL,
    output logic                  ADDR_VALID,
    output logic                  ADDR_ERR
);

    localparam int unsigned ADDR_W = $clog2(NUM_SLAVES + 1);
`ifdef SERIAL_ADDR_PARITY_EN
    localparam int unsigned XFER_BITS = ADDR_W + 1;
`else
    localparam int unsigned XFER_BITS = ADDR_W;
`endif
    localparam int unsigned      CNT_W    = $clog2(XFER_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(XFER_BITS - 1);
    localparam logic [ADDR_W-1:0] MAX_CODE = ADDR_W'(NUM_SLAVES);

    if (NUM_SLAVES < 1 || NUM_SLAVES > MAX_SLAVES) begin : g_param_check
        $fatal(1, "serial_addr_decoder: NUM_SLAVES=%0d outside 1..%0d",
               NUM_SLAVES, MAX_SLAVES);
    end

    addr_dec_state_t   state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt;
    logic              cnt_clr, cnt_inc;

    logic              capture;
    logic              last_bit;
    logic [ADDR_W-1:0] addr_cap;
    logic              parity_err;
    logic              code_err;

    addr_bit_counter #(
        .WIDTH(CNT_W)
    ) u_bit_counter (
        .CLK   (CLK),
        .RSTN  (RSTN),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .count (cnt)
    );

    assign capture  = B_UTIL & A_ADD;
    assign last_bit = (cnt == LAST_BIT);

    // Outside SHIFT the counter is zero and the capture starts a fresh
    // address, so the partial address is only carried while shifting.
    // The parity bit lands at index ADDR_W and shifts out of the address.
    assign addr_cap = ((state_q == SHIFT) ? addr_q : '0)
                    | (ADDR_W'(B_BUS_OUT) << cnt);

`ifdef SERIAL_ADDR_PARITY_EN
    // On the parity edge addr_q already holds the full address.
    assign parity_err = (^addr_q) ^ B_BUS_OUT;
`else
    assign parity_err = 1'b0;
`endif

    assign code_err = (addr_cap == '0) | (addr_cap > MAX_CODE) | parity_err;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= IDLE;
            addr_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // A capture behaves the same from every state: IDLE and HOLD begin a
    // new transfer (counter already zero), SHIFT continues the current one.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        err_d   = err_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;

        if (capture) begin
            addr_d = addr_cap;
            if (last_bit) begin
                state_d = HOLD;
                valid_d = 1'b1;
                err_d   = code_err;
                cnt_clr = 1'b1;
            end else begin
                state_d = SHIFT;
                valid_d = 1'b0;
                err_d   = 1'b0;
                cnt_inc = 1'b1;
            end
        end else begin
            case (state_q)
                SHIFT: begin
                    state_d = IDLE;
                    addr_d  = '0;
                    cnt_clr = 1'b1;
                end
                HOLD: begin
                    if (!B_UTIL) begin
                        state_d = IDLE;
                        addr_d  = '0;
                        valid_d = 1'b0;
                        err_d   = 1'b0;
                    end
                end
                IDLE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    addr_d  = '0;
                    valid_d = 1'b0;
                    err_d   = 1'b0;
                    cnt_clr = 1'b1;
                end
            endcase
        end
    end

    // Selects follow B_SBSY combinationally; slaves without split support
    // ignore their split-busy input.
    always_comb begin
        AD_SEL  = '0;
        SPL_SEL = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            AD_SEL[i]  = valid_q & ~err_q & (addr_q == ADDR_W'(i + 1))
                       & ~(SPLIT_MASK[i] & B_SBSY[i]);
            SPL_SEL[i] = valid_q & ~err_q & (addr_q == ADDR_W'(i + 1))
                       &  (SPLIT_MASK[i] & B_SBSY[i]);
        end
    end

    assign ADDR_VALID = valid_q;
    assign ADDR_ERR   = err_q;

endmodule

// File: doc/serial_addr_decoder.md
SERIAL_ADDR_DECODER -- requirements
Module: serial_addr_decoder

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 3, meaning number of decoded slave selects (1..15).
REQ-002 SHALL have parameter SPLIT_MASK, default NUM_SLAVES'b001, meaning bit i set means slave i supports split transactions.
REQ-003 SHALL have derived localparam ADDR_W = $clog2(NUM_SLAVES+1), meaning serial address bits per transfer.
REQ-004 CLK  input  1  clock; all state changes on the rising edge.
REQ-005 RSTN  input  1  reset, asynchronous, active-low.
REQ-006 B_UTIL  input  1  bus utilised; qualifies every other bus input.
REQ-007 A_ADD  input  1  address phase; high while address bits are on B_BUS_OUT.
REQ-008 B_BUS_OUT  input  1  serial bus bit, address sent LSB first.
REQ-009 B_SBSY  input  NUM_SLAVES  per-slave split-busy.
REQ-010 AD_SEL  output  NUM_SLAVES  one-hot slave select.
REQ-011 SPL_SEL  output  NUM_SLAVES  one-hot split-pending select.
REQ-012 ADDR_VALID  output  1  decoded address held and valid.
REQ-013 ADDR_ERR  output  1  held address decodes to no slave, or parity failed.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, HOLD.
REQ-015 A bit SHALL be captured only on edges where B_UTIL & A_ADD; the k-th captured bit goes to address bit k, and a bit counter increments per capture.
REQ-016 IDLE -> SHIFT on the first capture edge, which stores bit 0.
REQ-017 SHIFT -> HOLD on the edge capturing the final bit (ADDR_W bits, or ADDR_W+1 with parity); ADDR_VALID goes high the next cycle (1-cycle latency after the last bit).
REQ-018 In SHIFT, B_UTIL low or A_ADD low SHALL abort to IDLE with counter and partial address cleared and no error flagged.
REQ-019 HOLD SHALL persist while B_UTIL & ~A_ADD; B_UTIL low -> IDLE and ADDR_VALID clears on that edge.
REQ-020 In HOLD, B_UTIL & A_ADD SHALL start a new transfer: ADDR_VALID clears, this edge's bit is bit 0, state -> SHIFT (back-to-back addresses).
REQ-021 Address code c in 1..NUM_SLAVES selects slave c-1; code 0 or c>NUM_SLAVES gives ADDR_VALID=1, ADDR_ERR=1, AD_SEL=0, SPL_SEL=0.
REQ-022 AD_SEL[i] = ADDR_VALID & ~ADDR_ERR & code==i+1 & ~(SPLIT_MASK[i] & B_SBSY[i]), combinational, tracking B_SBSY with zero latency.
REQ-023 SPL_SEL[i] = ADDR_VALID & ~ADDR_ERR & code==i+1 & SPLIT_MASK[i] & B_SBSY[i]; AD_SEL and SPL_SEL SHALL never both be set for the same slave.
REQ-024 B_SBSY on slaves with SPLIT_MASK bit clear SHALL be ignored.
REQ-025 At most one bit of AD_SEL | SPL_SEL SHALL be high in any cycle.

Reset
REQ-026 RSTN low SHALL asynchronously force state IDLE, counter 0, address 0, ADDR_VALID=0, ADDR_ERR=0, hence AD_SEL=0 and SPL_SEL=0, including mid-SHIFT or in HOLD.
REQ-027 After RSTN deasserts, the first capture SHALL be treated as bit 0.

Configuration
REQ-028 Macro SERIAL_ADDR_PARITY_EN defined: one extra even-parity bit follows the address; on mismatch, HOLD is entered with ADDR_ERR=1 and no selects.
REQ-029 Macro SERIAL_ADDR_PARITY_EN undefined: no parity bit, transfer is exactly ADDR_W bits, ADDR_ERR reflects only out-of-range codes.

Structure
REQ-030 Package bus_pkg SHALL hold the enum type addr_dec_state_t (IDLE, SHIFT, HOLD) and the max slave count constant (15).
REQ-031 Sub-module addr_bit_counter (sync clear, increment, async reset, width parameter) SHALL hold the bit counter.
REQ-032 The parameter range SHALL be checked at elaboration; NUM_SLAVES outside 1..15 is a fatal error.

Verification (NUM_SLAVES=3, SPLIT_MASK=3'b001, parity off unless stated)
REQ-033 Bits 0,1 (code 2) on B_BUS_OUT with A_ADD, then B_UTIL&~A_ADD -> ADDR_VALID=1 and AD_SEL=3'b010 from the cycle after bit 1, held until B_UTIL falls.
REQ-034 Code 1 with B_SBSY=3'b001 -> SPL_SEL=3'b001 and AD_SEL=0; drop B_SBSY -> AD_SEL=3'b001 in the same cycle.
REQ-035 Code 0 -> ADDR_VALID=1, ADDR_ERR=1, AD_SEL=0, SPL_SEL=0.
REQ-036 Back-to-back code 3 then code 1 with no idle cycle between -> AD_SEL 3'b100, then 0 during the second capture, then 3'b001.
REQ-037 RSTN low after one captured bit, then code 2 sent -> outputs 0 during reset, then AD_SEL=3'b010 after the two new bits.
REQ-038 SERIAL_ADDR_PARITY_EN, code 3 with parity bit 1 -> ADDR_ERR=1, AD_SEL=0; parity bit 0 -> AD_SEL=3'b100.
